// File: rtl/spy_pkg.sv
// Shared encodings for the spy-bus boot sequencer: command ops, result codes,
// FSM states and the fixed mode words driven for RESET and BOOT.
package spy_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'b00,
    OP_BOOT    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } spy_op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ERR     = 2'b10,
    ST_ILLEGAL = 2'b11
  } spy_status_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_DRIVE    = 2'b01,
    S_WAIT_RUN = 2'b10,
    S_DONE     = 2'b11
  } spy_state_e;

  localparam logic [15:0] MODE_RESET = 16'h0040;
  localparam logic [15:0] MODE_BOOT  = 16'h0080;

endpackage

// File: rtl/spy_cycle_timer.sv
// Loadable 16-bit down-counter; sticks at zero rather than wrapping.
module spy_cycle_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 16'd0)) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 16'd0);

endmodule

// File: rtl/spy_boot_seq.sv
// Host-command sequencer that drives mode words onto the spy bus with an
// ldmode strobe and, for BOOT, waits for the processor to start running.
module spy_boot_seq
  import spy_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        ldmode,
  output logic [15:0] spy_out,
  input  logic        srun,
  input  logic        boot_trap,
  input  logic        err,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output spy_state_e  dbg_state
);

  // Handshake: a command is taken on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE and nothing queues.

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC - 1);

  spy_state_e  state_q, state_d;
  spy_op_e     op_q, op_d;
  logic [15:0] data_q, data_d;
  spy_status_e status_q, status_d;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_dec;
  logic        tmr_zero;

  spy_cycle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    status_d = status_q;
    tmr_load = 1'b0;
    tmr_val  = 16'd0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = spy_op_e'(cmd_op);
          data_d = cmd_data;
          if (spy_op_e'(cmd_op) == OP_ILLEGAL) begin
            state_d  = S_DONE;
            status_d = ST_ILLEGAL;
          end else begin
            state_d  = S_DRIVE;
            tmr_load = 1'b1;
            tmr_val  = (spy_op_e'(cmd_op) == OP_WRITE) ? 16'd0 : HOLD_LOAD;
          end
        end
      end
      S_DRIVE: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (op_q == OP_BOOT) begin
          state_d  = S_WAIT_RUN;
          tmr_load = 1'b1;
          tmr_val  = TMO_LOAD;
        end else begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end
      end
      S_WAIT_RUN: begin
        // Error outranks a run indication, which outranks the timeout.
        if (err) begin
          state_d  = S_DONE;
          status_d = ST_ERR;
        end else if (srun && !boot_trap) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (tmr_zero) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_RESET;
      data_q   <= 16'd0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    spy_out = 16'd0;
    if (state_q == S_DRIVE) begin
      case (op_q)
        OP_RESET: spy_out = MODE_RESET;
        OP_BOOT:  spy_out = MODE_BOOT;
        OP_WRITE: spy_out = data_q;
        default:  spy_out = 16'd0;
      endcase
    end
  end

  assign ldmode    = (state_q == S_DRIVE);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign status    = status_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spy_boot_seq.sv
// Directed and randomized checks of spy_boot_seq against a cycle-count model
// derived from the command rules (drive length, wait outcome, done latency).
module tb_spy_boot_seq;
  import spy_pkg::*;

  localparam int HOLD = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        ldmode;
  logic [15:0] spy_out;
  logic        srun;
  logic        boot_trap;
  logic        err;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  spy_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spy_boot_seq #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .ldmode    (ldmode),
    .spy_out   (spy_out),
    .srun      (srun),
    .boot_trap (boot_trap),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Processor-side inputs as a function of the cycle index after accept.
  task automatic drive_env(input int c, input int sr_k, input int er_k, input bit trap_hold);
    srun      = (c >= HOLD + sr_k);
    boot_trap = trap_hold ? 1'b1 : !(c >= HOLD + sr_k);
    err       = (er_k != 0) && (c >= HOLD + er_k);
  endtask

  // Issues one command from IDLE and checks every cycle up to one past done.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [15:0] data,
                         input int sr_k, input int er_k, input bit trap_hold);
    int          drive_len;
    int          done_c;
    logic [1:0]  exp_st;
    logic [15:0] word;
    bit          found;
    drive_len = 0;
    done_c    = 1;
    exp_st    = 2'b00;
    word      = 16'h0000;
    found     = 1'b0;
    case (op)
      2'b00: begin drive_len = HOLD; word = 16'h0040; done_c = HOLD + 1; exp_st = 2'b00; end
      2'b01: begin
        drive_len = HOLD;
        word      = 16'h0080;
        for (int k = 1; k <= TMO; k++) begin
          if (!found) begin
            if ((er_k != 0) && (k >= er_k)) begin exp_st = 2'b10; found = 1'b1; end
            else if ((k >= sr_k) && !trap_hold) begin exp_st = 2'b00; found = 1'b1; end
            else if (k == TMO) begin exp_st = 2'b01; found = 1'b1; end
            if (found) done_c = HOLD + 1 + k;
          end
        end
      end
      2'b10: begin drive_len = 1; word = data; done_c = 2; exp_st = 2'b00; end
      default: begin drive_len = 0; word = 16'h0000; done_c = 1; exp_st = 2'b11; end
    endcase

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    drive_env(0, sr_k, er_k, trap_hold);
    for (int c = 1; c <= done_c + 1; c++) begin
      step();
      chk($sformatf("%s c%0d ldmode", name, c), 32'(ldmode), 32'(c <= drive_len));
      chk($sformatf("%s c%0d spy_out", name, c), 32'(spy_out), (c <= drive_len) ? 32'(word) : 32'd0);
      chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == done_c));
      chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= done_c));
      chk($sformatf("%s c%0d cmd_ready", name, c), 32'(cmd_ready), 32'(c > done_c));
      if (c >= done_c) chk($sformatf("%s c%0d status", name, c), 32'(status), 32'(exp_st));
      // Keep requesting while busy; those requests must be ignored.
      cmd_valid = (c < done_c);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 16'($urandom);
      drive_env(c, sr_k, er_k, trap_hold);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
    srun      = 1'b0;
    boot_trap = 1'b0;
    err       = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset ldmode", 32'(ldmode), 32'd0);
    chk("reset spy_out", 32'(spy_out), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset status", 32'(status), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    step();

    run_cmd("reset_op", 2'b00, 16'h0000, 100, 0, 1'b0);
    run_cmd("write_op", 2'b10, 16'h1234, 100, 0, 1'b0);
    run_cmd("boot_run", 2'b01, 16'h0000, 6, 0, 1'b0);
    run_cmd("boot_tmo", 2'b01, 16'h0000, 100, 0, 1'b0);
    run_cmd("boot_err", 2'b01, 16'h0000, 3, 3, 1'b0);
    run_cmd("boot_trap", 2'b01, 16'h0000, 2, 0, 1'b1);
    run_cmd("illegal_op", 2'b11, 16'hBEEF, 100, 0, 1'b0);

    // Abort a RESET command at its second drive cycle.
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort c2 ldmode", 32'(ldmode), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort c3 ldmode", 32'(ldmode), 32'd0);
    chk("abort c3 spy_out", 32'(spy_out), 32'd0);
    chk("abort c3 cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort c3 busy", 32'(busy), 32'd0);
    chk("abort c3 status", 32'(status), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort post%0d done", i), 32'(done), 32'd0);
      chk($sformatf("abort post%0d ldmode", i), 32'(ldmode), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      logic [1:0]  rop;
      logic [15:0] rdata;
      int          rsr;
      int          rer;
      bit          rtrap;
      rop   = 2'($urandom_range(0, 3));
      rdata = 16'($urandom);
      rsr   = $urandom_range(1, TMO + 3);
      rer   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 3) : 0;
      rtrap = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d_op%0d", t, rop), rop, rdata, rsr, rer, rtrap);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step();
        chk($sformatf("rnd%0d gap ready", t), 32'(cmd_ready), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_boot_seq.md
SPY_BOOT_SEQ -- requirements
Module: spy_boot_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 4, giving the number of cycles ldmode is held for RESET and BOOT commands (legal range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the maximum WAIT_RUN cycles before a timeout (legal range 1..65535).
REQ-003 The block SHALL have ports: clk  in  1  system clock (one clock; all logic on posedge clk).
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  host command request; cmd_ready  out  1  high only in IDLE.
REQ-006 cmd_op  in  2  00=RESET, 01=BOOT, 10=WRITE, 11=reserved; cmd_data  in  16  mode word for WRITE.
REQ-007 ldmode  out  1  mode-register load strobe to the overlord; spy_out  out  16  mode word on the spy bus.
REQ-008 srun  in  1  processor running; boot_trap  in  1  boot trap pending; err  in  1  processor halted on error.
REQ-009 busy  out  1  high in any state but IDLE; done  out  1  one-cycle completion pulse; status  out  2  result, valid with done, held until the next done.

Function
REQ-010 A command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both high; cmd_op/cmd_data SHALL be latched on that edge.
REQ-011 States SHALL be IDLE, DRIVE, WAIT_RUN, DONE; IDLE->DRIVE on accept for ops 00/01/10, IDLE->DONE on accept for op 11.
REQ-012 In DRIVE, ldmode SHALL be 1 and spy_out SHALL be 16'h0040 (RESET), 16'h0080 (BOOT) or the latched cmd_data (WRITE).
REQ-013 DRIVE SHALL last HOLD_CYC cycles for RESET/BOOT and exactly 1 cycle for WRITE, beginning the cycle after accept.
REQ-014 Whenever ldmode is 0, spy_out SHALL be 16'h0000.
REQ-015 After DRIVE, RESET and WRITE SHALL go to DONE with status 00 (OK); BOOT SHALL go to WAIT_RUN.
REQ-016 In WAIT_RUN, evaluated each cycle with priority err > run > timeout: err=1 -> DONE status 10 (ERR); srun=1 and boot_trap=0 -> DONE status 00; TIMEOUT_CYC cycles elapsed in WAIT_RUN -> DONE status 01 (TIMEOUT).
REQ-017 The WAIT_RUN counter SHALL be 16 bits, cleared on entry, and SHALL saturate, never wrap.
REQ-018 Op 11 SHALL complete via DONE with status 11 (ILLEGAL) and no ldmode activity.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; cmd_ready SHALL be 0 in DONE.
REQ-020 cmd_valid while not IDLE SHALL be ignored (no queueing).
REQ-021 Total latency accept->done SHALL be HOLD_CYC+1 cycles for RESET, 2 for WRITE, 1 for op 11, and HOLD_CYC+1+k for BOOT where k is the WAIT_RUN cycle count (k>=1).

Reset
REQ-022 On reset the state SHALL go to IDLE; ldmode=0, spy_out=0, done=0, busy=0, status=00, cmd_ready=1 from the following cycle.
REQ-023 Reset mid-operation SHALL abort the command without a done pulse, ldmode SHALL drop at that edge, and the counters SHALL clear.

Structure
REQ-024 Op codes, status codes, state encoding and the mode-word constants 16'h0040/16'h0080 SHALL live in shared package spy_pkg.
REQ-025 One sub-module, spy_cycle_timer (loadable 16-bit down-counter with a zero flag), SHALL serve both the HOLD and WAIT_RUN counts.

Verification
REQ-026 RESET: accept op 00 at cycle 0 -> ldmode=1, spy_out=0x0040 in cycles 1-4, done=1 with status 00 at cycle 5.
REQ-027 WRITE: op 10, cmd_data=0x1234 -> ldmode=1, spy_out=0x1234 for cycle 1 only, done with status 00 at cycle 2.
REQ-028 BOOT: op 01, boot_trap=1 until srun rises at cycle 10 (boot_trap falls the same cycle) -> ldmode cycles 1-4, done with status 00 at cycle 11.
REQ-029 BOOT timeout: TIMEOUT_CYC=16, srun held 0 -> done with status 01 at cycle 4+1+16=21; err and srun rising together -> status 10.
REQ-030 Abort: reset asserted at cycle 2 of RESET -> ldmode=0 from cycle 3, no done, cmd_ready=1 at cycle 3; op 11 -> done with status 11 at cycle 1 and no ldmode.
